slow_clock_monitor: RTL
=======================

# slow_clock_monitor

Receives the divided slow clock produced by the team's clock divider and brings it back into the fast `clkin` domain. It synchronises the slow clock and emits one-cycle rise and fall tick enables, so elevator FSMs can run on `clkin` with clock enables instead of a derived clock. It also measures each half period, checks it against the divider's programmed offset, and flags loss of lock or a stalled slow clock.

## Interface
- `OFFSET`, default 1: expected `clkin` cycles per slow-clock half period. Must match the divider's offset parameter; must be ≥ 1.
- `TOL`, default 0: allowed absolute deviation of a measured half period from `OFFSET`.
- `STALL_CYCLES`, default 64: number of `clkin` cycles without a slow-clock edge that declares a stall. Must be greater than `OFFSET + TOL`.
- `clkin` input, 1 bit: the only clock. All logic is on its rising edge.
- `rst_n` input, 1 bit: reset. Synchronous, active-low.
- `slow_clk` input, 1 bit: the divided clock. It is treated as asynchronous.
- `tick_rise` output, 1 bit: one-cycle pulse for each synchronised rising edge.
- `tick_fall` output, 1 bit: one-cycle pulse for each synchronised falling edge.
- `half_period` output, 32 bits: the last captured half-period length, in `clkin` cycles.
- `locked` output, 1 bit: high while in the LOCKED state.
- `stalled` output, 1 bit: high while in the STALLED state.
- `err_count` output, 8 bits: saturating count of out-of-tolerance half periods seen while LOCKED.

## Operation
- **Synchroniser.** A three-flop chain `s1 <= slow_clk`, `s2 <= s1`, `s3 <= s2`.
  - `edge = s2 ^ s3`.
  - Rising edge is `s2 & ~s3`; falling edge is `~s2 & s3`.
  - Both ticks are registered.
- **Interval counter.** `cnt` is 32 bits.
  - On a cycle with `edge`: `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`, saturating at `0xFFFF_FFFF`.
  - On an edge, `cnt` holds the number of cycles since the previous edge.
- **In-tolerance test.** `|cnt - OFFSET| <= TOL`. Compute it with 33-bit signed arithmetic; no wrap is allowed.
- **FSM states:** ACQUIRE, MEASURE, LOCKED, STALLED.
  - ACQUIRE: on `edge`, go to MEASURE. Nothing is captured, because the first interval is partial.
  - MEASURE: on `edge`, capture `half_period <= cnt`. If in tolerance, go to LOCKED; otherwise stay in MEASURE. `err_count` is unchanged.
  - LOCKED: on `edge`, capture `half_period`. If out of tolerance, go to MEASURE and increment `err_count`, saturating at 255.
  - STALLED: on `edge`, go to MEASURE without capturing, because the interval is invalid.
  - From any state except STALLED: if there is no `edge` and `cnt >= STALL_CYCLES`, go to STALLED.
  - When an edge and the stall condition occur in the same cycle, the edge wins.
- **Outputs.** `locked` and `stalled` are decoded from the state register and are glitch-free. Ticks are emitted in every state, including STALLED.

## Timing
- **Reset.** While `rst_n == 0` at a `clkin` edge, all of the following are cleared on that edge:
  - `s1`, `s2`, `s3` = 0
  - `cnt` = 0
  - state = ACQUIRE
  - `tick_rise`, `tick_fall`, `half_period`, `locked`, `stalled`, `err_count` = 0
- **Reset mid-operation.** A one-cycle reset mid-operation fully clears all of the above; no partial state survives.
- **Reset release with `slow_clk` high.** This produces exactly one spurious `tick_rise`. This is accepted behaviour. Measurement is unaffected because ACQUIRE discards that interval.
- **Tick latency.** If `slow_clk` changes and meets setup before `clkin` edge k:
  - `s1` updates at k, `s2` at k+1.
  - The tick is registered at edge k+2 and is high for exactly the one cycle between k+2 and k+3.
- **Capture timing.** `half_period`, state, `locked`, `stalled` and `err_count` all update on the same edge that registers the tick.
- **Steady state.** With the divider at offset N, edges are N cycles apart and the captured `half_period` is N. `OFFSET = 1` gives an edge every cycle and `half_period = 1`.
- **Lock timing.** From reset with a toggling `slow_clk`, `locked` rises at the second detected edge (the first valid capture).
- **Stall timing.** `stalled` rises on the cycle after `cnt` reaches `STALL_CYCLES` with no edge, i.e. `STALL_CYCLES` cycles after the last edge's tick. `locked` falls on the same edge.

## Test plan
- **Nominal lock.** `OFFSET=3`, `TOL=0`; `slow_clk` toggles every 3 `clkin` cycles → `tick_rise`/`tick_fall` alternate every 3 cycles, `half_period=3`, `locked=1` from the second tick onward, `err_count=0`.
- **Latency.** A single 0→1 step of `slow_clk` before edge k → `tick_rise` is high exactly between edges k+2 and k+3, and `tick_fall` stays 0.
- **Stall and recovery.** `STALL_CYCLES=16`, locked, then hold `slow_clk` → 16 cycles after the last tick `stalled=1` and `locked=0`. Resume toggling → MEASURE on the first edge, LOCKED on the second, `stalled=0`.
- **Tolerance.** `OFFSET=3`, `TOL=1`, locked; inject one 5-cycle half period → `half_period=5`, `locked=0`, `err_count=1`. The next 3-cycle interval relocks. A 4-cycle interval keeps lock.
- **Saturation.** Alternate good and bad intervals 300 times → `err_count` stays at 255.
- **Reset mid-run.** Pulse `rst_n=0` for one cycle while locked with `err_count=2` → all outputs are 0 on the following cycle. Relock then occurs after two edges.

Source files
------------

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor
// Brings the divider's slow clock into the clkin domain. It produces one-cycle
// rise/fall tick enables, measures every half period, and tracks lock/stall.

module slow_clock_monitor #(
    parameter int unsigned OFFSET       = 1,
    parameter int unsigned TOL          = 0,
    parameter int unsigned STALL_CYCLES = 64
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic        slow_clk,
    output logic        tick_rise,
    output logic        tick_fall,
    output logic [31:0] half_period,
    output logic        locked,
    output logic        stalled,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        STALLED = 2'd3
    } monState_e;

    localparam logic [31:0]        CNT_MAX      = 32'hFFFF_FFFF;
    localparam logic [31:0]        STALL_LIMIT  = 32'(STALL_CYCLES);
    localparam logic signed [32:0] OFFSET_S     = 33'(OFFSET);
    localparam logic signed [32:0] TOL_S        = 33'(TOL);
    localparam logic [7:0]         ERR_MAX      = 8'hFF;

    logic        sync1_q;
    logic        sync2_q;
    logic        sync3_q;
    logic        tickRise_q;
    logic        tickFall_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] halfPeriod_q;
    logic [31:0] halfPeriod_d;
    logic [7:0]  errCount_q;
    logic [7:0]  errCount_d;
    monState_e   state_q;
    monState_e   state_d;

    logic               slowEdge;
    logic               slowRise;
    logic               slowFall;
    logic               stallHit;
    logic signed [32:0] diffS;
    logic signed [32:0] absDiff;
    logic               inTol;

    // Edge detection looks at the two older synchroniser stages only
    assign slowEdge = sync2_q ^ sync3_q;
    assign slowRise = sync2_q & ~sync3_q;
    assign slowFall = ~sync2_q & sync3_q;

    // Stall means a long quiet interval; a simultaneous edge takes priority
    assign stallHit = ~slowEdge && (cnt_q >= STALL_LIMIT);

    // Distance of the measured interval from the expected one, widened so it never wraps
    assign diffS   = $signed({1'b0, cnt_q}) - OFFSET_S;
    assign absDiff = diffS[32] ? -diffS : diffS;
    assign inTol   = (absDiff <= TOL_S);

    // Three-flop synchroniser for the asynchronous slow clock
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= slow_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Registered tick enables, emitted in every state
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            tickRise_q <= 1'b0;
            tickFall_q <= 1'b0;
        end else begin
            tickRise_q <= slowRise;
            tickFall_q <= slowFall;
        end
    end

    // Interval counter: restarts at one on each edge, otherwise counts up and saturates
    always_comb begin
        cnt_d = cnt_q;
        if (slowEdge) begin
            cnt_d = 32'd1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Lock FSM next state, half-period capture and error counting
    always_comb begin
        state_d      = state_q;
        halfPeriod_d = halfPeriod_q;
        errCount_d   = errCount_q;
        unique case (state_q)
            ACQUIRE: begin
                if (slowEdge) begin
                    state_d = MEASURE;
                end else if (stallHit) begin
                    state_d = STALLED;
                end
            end
            MEASURE: begin
                if (slowEdge) begin
                    halfPeriod_d = cnt_q;
                    if (inTol) begin
                        state_d = LOCKED;
                    end
                end else if (stallHit) begin
                    state_d = STALLED;
                end
            end
            LOCKED: begin
                if (slowEdge) begin
                    halfPeriod_d = cnt_q;
                    if (!inTol) begin
                        state_d = MEASURE;
                        if (errCount_q != ERR_MAX) begin
                            errCount_d = errCount_q + 8'd1;
                        end
                    end
                end else if (stallHit) begin
                    state_d = STALLED;
                end
            end
            STALLED: begin
                if (slowEdge) begin
                    state_d = MEASURE;
                end
            end
            default: begin
                state_d = ACQUIRE;
            end
        endcase
    end

    // FSM state, captured half period and error count registers
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_q      <= ACQUIRE;
            halfPeriod_q <= 32'd0;
            errCount_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            halfPeriod_q <= halfPeriod_d;
            errCount_q   <= errCount_d;
        end
    end

    assign tick_rise   = tickRise_q;
    assign tick_fall   = tickFall_q;
    assign half_period = halfPeriod_q;
    assign err_count   = errCount_q;
    assign locked      = (state_q == LOCKED);
    assign stalled     = (state_q == STALLED);

endmodule
